// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the LSU/JTAG single-port RAM arbiter.
package ram_arb_pkg;

   localparam int unsigned DEF_STARVE_MAX = 4;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned SEL_W          = 4;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_DROP = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic              ce;
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ram_req_t;

endpackage

// File: rtl/ram_access_arbiter.sv
// Arbitrates a single-port RAM between the core LSU and a 4-phase JTAG master,
// bounding JTAG starvation to STARVE_MAX consecutive LSU grants.
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              lsu_ce_i,
   input  logic              lsu_we_i,
   input  logic [SEL_W-1:0]  lsu_sel_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   output logic              lsu_stall_o,
   output logic              lsu_rvalid_o,
   output logic [DATA_W-1:0] lsu_data_o,
   input  logic              jtag_halt_i,
   input  logic              jtag_req_i,
   input  logic              jtag_we_i,
   input  logic [SEL_W-1:0]  jtag_sel_i,
   input  logic [ADDR_W-1:0] jtag_addr_i,
   input  logic [DATA_W-1:0] jtag_data_i,
   output logic              jtag_gnt_o,
   output logic              jtag_rvalid_o,
   output logic [DATA_W-1:0] jtag_data_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [SEL_W-1:0]  ram_sel_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_data_o,
   input  logic [DATA_W-1:0] ram_data_i
);

   localparam int unsigned    CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
   logic             jtag_win_c;
   ram_req_t         lsu_req_c, jtag_req_c, ram_req_c;

   assign lsu_req_c  = '{ce: lsu_ce_i, we: lsu_we_i, sel: lsu_sel_i,
                         addr: lsu_addr_i, data: lsu_data_i};
   assign jtag_req_c = '{ce: 1'b1, we: jtag_we_i, sel: jtag_sel_i,
                         addr: jtag_addr_i, data: jtag_data_i};

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Grant decision, starvation counter and RAM port mux.
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      jtag_win_c     = 1'b0;
      ram_req_c      = '0;
      jtag_gnt_o     = 1'b0;
      lsu_stall_o    = 1'b0;

      case (state)
         IDLE: begin
            // Reset is folded in so a grant in progress is dropped immediately.
            jtag_win_c = n_rst_i && jtag_req_i &&
                         (jtag_halt_i || !lsu_ce_i || (starve_cnt == CNT_MAX));
            if (jtag_win_c) begin
               state_nxt      = WAIT_DROP;
               starve_cnt_nxt = '0;
            end else if (jtag_req_i && lsu_ce_i && (starve_cnt != CNT_MAX)) begin
               starve_cnt_nxt = starve_cnt + 1'b1;
            end
         end
         WAIT_DROP: begin
            if (!jtag_req_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (!jtag_req_i) starve_cnt_nxt = '0;

      if (jtag_win_c) begin
         ram_req_c   = jtag_req_c;
         jtag_gnt_o  = 1'b1;
         lsu_stall_o = lsu_ce_i;
      end else if (lsu_ce_i) begin
         ram_req_c = lsu_req_c;
      end

      lsu_rvalid_o = lsu_ce_i & ~lsu_we_i & ~lsu_stall_o;
      lsu_data_o   = lsu_rvalid_o ? ram_data_i : '0;
   end

   assign ram_ce_o   = ram_req_c.ce;
   assign ram_we_o   = ram_req_c.we;
   assign ram_sel_o  = ram_req_c.sel;
   assign ram_addr_o = ram_req_c.addr;
   assign ram_data_o = ram_req_c.data;

   // Capture JTAG read data at the grant edge; held until the next JTAG read.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         jtag_rvalid_o <= 1'b0;
         jtag_data_o   <= '0;
      end else begin
         jtag_rvalid_o <= jtag_win_c & ~jtag_we_i;
         if (jtag_win_c && !jtag_we_i) jtag_data_o <= ram_data_i;
      end
   end

endmodule
